// File: rtl/fb_port_arbiter_if.sv
// Bundle of scan, host and framebuffer-RAM signals around fb_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fb_port_arbiter_if #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int COLOR_DEPTH = 1
);
    localparam int COL_BITS  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int RGB_WIDTH = 3 * COLOR_DEPTH;

    logic                 SCAN_REQ;
    logic [ADDR_BITS-1:0] SCAN_ADDR;
    logic                 SCAN_READY;
    logic [RGB_WIDTH-1:0] SCAN_DATA;
    logic                 SCAN_VALID;

    logic                 HOST_VALID;
    logic                 HOST_READY;
    logic                 HOST_WE;
    logic [ADDR_BITS-1:0] HOST_ADDR;
    logic [RGB_WIDTH-1:0] HOST_WDATA;
    logic [RGB_WIDTH-1:0] HOST_RDATA;
    logic                 HOST_RVALID;

    logic [ADDR_BITS-1:0] FB_ADDR;
    logic                 FB_WE;
    logic [RGB_WIDTH-1:0] FB_WDATA;
    logic [RGB_WIDTH-1:0] FB_RDATA;

    logic [15:0]          STALL_COUNT;

    modport slave (
        input  SCAN_REQ, SCAN_ADDR, HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA, FB_RDATA,
        output SCAN_READY, SCAN_DATA, SCAN_VALID, HOST_READY, HOST_RDATA, HOST_RVALID,
               FB_ADDR, FB_WE, FB_WDATA, STALL_COUNT
    );

    modport master (
        output SCAN_REQ, SCAN_ADDR, HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA, FB_RDATA,
        input  SCAN_READY, SCAN_DATA, SCAN_VALID, HOST_READY, HOST_RDATA, HOST_RVALID,
               FB_ADDR, FB_WE, FB_WDATA, STALL_COUNT
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scan engine has priority, host fills free cycles.
// Define FB_ARB_STARVE_GUARD_EN to force a host slot after MAX_WAIT waiting cycles.
module fb_port_arbiter #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int COLOR_DEPTH = 1,
    parameter int MAX_WAIT    = 8
) (
    input logic          CLOCK,
    input logic          RESET_N,
    fb_port_arbiter_if.slave bus
);
    localparam int COL_BITS  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int RGB_WIDTH = 3 * COLOR_DEPTH;

    typedef struct packed {
        logic valid;
        logic host;
        logic zero;
    } tag_t;

    logic                 force_host;
    logic                 scan_grant;
    logic                 host_grant;
    logic                 scan_col_ok;
    logic                 host_col_ok;

    logic [ADDR_BITS-1:0] fb_addr_reg;
    logic                 fb_we_reg;
    logic [RGB_WIDTH-1:0] fb_wdata_reg;
    logic [RGB_WIDTH-1:0] scan_data_reg;
    logic                 scan_valid_reg;
    logic [RGB_WIDTH-1:0] host_rdata_reg;
    logic                 host_rvalid_reg;
    logic [15:0]          stall_reg;

    tag_t                 tag_in;
    tag_t                 tag_reg [2];
    tag_t                 tag_d   [3];
    logic [RGB_WIDTH-1:0] rd_data;

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int WAIT_BITS = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    logic [WAIT_BITS-1:0] wait_reg;
    logic [WAIT_BITS-1:0] wait_next;

    assign force_host = bus.HOST_VALID && (wait_reg == WAIT_BITS'(MAX_WAIT));

    always_comb begin
        wait_next = wait_reg;
        if (!bus.HOST_VALID || host_grant) begin
            wait_next = '0;
        end else if (wait_reg != WAIT_BITS'(MAX_WAIT)) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_next;
        end
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign force_host      = 1'b0;
`endif

    assign scan_grant     = bus.SCAN_REQ & ~force_host;
    assign host_grant     = bus.HOST_VALID & (~bus.SCAN_REQ | force_host);
    assign bus.SCAN_READY = scan_grant;
    assign bus.HOST_READY = host_grant;

    // Out-of-range columns only exist when COLS is not a power of two.
    generate
        if (COLS == (1 << COL_BITS)) begin : g_col_full
            assign scan_col_ok = 1'b1;
            assign host_col_ok = 1'b1;
        end else begin : g_col_part
            localparam logic [COL_BITS-1:0] COL_LIMIT = COL_BITS'(COLS);
            assign scan_col_ok = bus.SCAN_ADDR[COL_BITS-1:0] < COL_LIMIT;
            assign host_col_ok = bus.HOST_ADDR[COL_BITS-1:0] < COL_LIMIT;
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            fb_addr_reg  <= '0;
            fb_we_reg    <= 1'b0;
            fb_wdata_reg <= '0;
        end else begin
            fb_we_reg <= 1'b0;
            if (scan_grant) begin
                fb_addr_reg <= bus.SCAN_ADDR;
            end else if (host_grant) begin
                fb_addr_reg  <= bus.HOST_ADDR;
                fb_we_reg    <= bus.HOST_WE & host_col_ok;
                fb_wdata_reg <= bus.HOST_WDATA;
            end
        end
    end

    // Tag follows each read through address register and RAM output register.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = scan_grant | (host_grant & ~bus.HOST_WE);
        tag_in.host  = host_grant;
        tag_in.zero  = scan_grant ? ~scan_col_ok : ~host_col_ok;
    end

    assign tag_d[0] = tag_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tag
            assign tag_d[gi+1] = tag_reg[gi];
            always_ff @(posedge CLOCK) begin
                if (!RESET_N) begin
                    tag_reg[gi] <= '0;
                end else begin
                    tag_reg[gi] <= tag_d[gi];
                end
            end
        end
    endgenerate

    assign rd_data = tag_d[2].zero ? '0 : bus.FB_RDATA;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            scan_data_reg   <= '0;
            scan_valid_reg  <= 1'b0;
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
        end else begin
            scan_valid_reg  <= tag_d[2].valid & ~tag_d[2].host;
            host_rvalid_reg <= tag_d[2].valid & tag_d[2].host;
            if (tag_d[2].valid && !tag_d[2].host) begin
                scan_data_reg <= rd_data;
            end
            if (tag_d[2].valid && tag_d[2].host) begin
                host_rdata_reg <= rd_data;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            stall_reg <= '0;
        end else if (bus.HOST_VALID && !host_grant && stall_reg != 16'hFFFF) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign bus.FB_ADDR     = fb_addr_reg;
    assign bus.FB_WE       = fb_we_reg;
    assign bus.FB_WDATA    = fb_wdata_reg;
    assign bus.SCAN_DATA   = scan_data_reg;
    assign bus.SCAN_VALID  = scan_valid_reg;
    assign bus.HOST_RDATA  = host_rdata_reg;
    assign bus.HOST_RVALID = host_rvalid_reg;
    assign bus.STALL_COUNT = stall_stall_out();

    function automatic logic [15:0] stall_stall_out();
        return stall_reg;
    endfunction
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a behavioural RAM and reference model.
// Honours FB_ARB_STARVE_GUARD_EN the same way the design does.
module tb_fb_port_arbiter;
    localparam int COLS        = 32;
    localparam int ROWS        = 16;
    localparam int COLOR_DEPTH = 1;
    localparam int MAX_WAIT    = 8;
    localparam int COL_BITS    = $clog2(COLS);
    localparam int ROW_BITS    = $clog2(ROWS);
    localparam int A           = ROW_BITS + COL_BITS;
    localparam int W           = 3 * COLOR_DEPTH;
    localparam int DEPTH       = 1 << A;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;

    fb_port_arbiter_if #(.COLS(COLS), .ROWS(ROWS), .COLOR_DEPTH(COLOR_DEPTH)) bus ();

    fb_port_arbiter #(
        .COLS(COLS), .ROWS(ROWS), .COLOR_DEPTH(COLOR_DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLOCK = ~CLOCK;

    // Framebuffer RAM with one-cycle registered read.
    logic [W-1:0] ram [DEPTH];
    logic         ram_init_done = 1'b0;
    always @(posedge CLOCK) begin
        if (!ram_init_done) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            ram_init_done <= 1'b1;
        end else if (bus.FB_WE) begin
            ram[bus.FB_ADDR] <= bus.FB_WDATA;
        end
        bus.FB_RDATA <= ram[bus.FB_ADDR];
    end

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [W-1:0] mem_m [DEPTH];
    exp_t         scan_q[$];
    exp_t         host_q[$];
    logic [15:0]  stall_m    = '0;
    logic         fb_we_m    = 1'b0;
    logic [A-1:0] fb_addr_m  = '0;
    logic [W-1:0] fb_wdata_m = '0;
    logic [W-1:0] last_scan  = '0;
    logic [W-1:0] last_host  = '0;
    logic         scan_taken = 1'b0;
    logic         host_taken = 1'b0;
    logic         force_m;
    logic         exp_scan_ready;
    logic         exp_host_ready;

`ifdef FB_ARB_STARVE_GUARD_EN
    int wait_m = 0;
    assign force_m = bus.HOST_VALID && (wait_m == MAX_WAIT);
`else
    assign force_m = 1'b0;
`endif
    assign exp_scan_ready = bus.SCAN_REQ && !force_m;
    assign exp_host_ready = bus.HOST_VALID && (!bus.SCAN_REQ || force_m);

    function automatic logic col_ok(input logic [A-1:0] a);
        return int'(a[COL_BITS-1:0]) < COLS;
    endfunction

    function automatic logic [A-1:0] mk(input int row, input int col);
        return {ROW_BITS'(row), COL_BITS'(col)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        bus.SCAN_REQ   = 1'b0;
        bus.HOST_VALID = 1'b0;
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic wait_scan_accept();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK);
            if (exp_scan_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("scan_accept_timeout", bus.SCAN_READY, 1);
        @(posedge CLOCK);
        #1;
    endtask

    task automatic scan_read(input logic [A-1:0] a);
        bus.SCAN_REQ  = 1'b1;
        bus.SCAN_ADDR = a;
        wait_scan_accept();
        bus.SCAN_REQ = 1'b0;
    endtask

    task automatic scan_stream(input int n, input int row);
        bus.SCAN_REQ = 1'b1;
        for (int k = 0; k < n; k++) begin
            bus.SCAN_ADDR = mk(row, k);
            wait_scan_accept();
        end
        bus.SCAN_REQ = 1'b0;
    endtask

    task automatic host_cmd(input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
        logic ok;
        bus.HOST_VALID = 1'b1;
        bus.HOST_WE    = we;
        bus.HOST_ADDR  = a;
        bus.HOST_WDATA = d;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK);
            if (exp_host_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("host_accept_timeout", bus.HOST_READY, 1);
        @(posedge CLOCK);
        #1;
        bus.HOST_VALID = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        bus.SCAN_REQ   = 1'b0;
        bus.SCAN_ADDR  = '0;
        bus.HOST_VALID = 1'b0;
        bus.HOST_WE    = 1'b0;
        bus.HOST_ADDR  = '0;
        bus.HOST_WDATA = '0;

        fork
            // Reference model: advances on every active edge.
            forever begin
                logic s_acc, h_acc, hr;
                @(posedge CLOCK);
                cyc++;
                hr    = exp_host_ready;
                s_acc = exp_scan_ready && RESET_N;
                h_acc = hr && RESET_N;
                if (!RESET_N) begin
                    scan_q.delete();
                    host_q.delete();
                    stall_m   = '0;
                    fb_we_m   = 1'b0;
                    fb_addr_m = '0;
                    fb_wdata_m = '0;
                    last_scan = '0;
                    last_host = '0;
`ifdef FB_ARB_STARVE_GUARD_EN
                    wait_m = 0;
`endif
                end else begin
                    if (bus.HOST_VALID && !hr && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`ifdef FB_ARB_STARVE_GUARD_EN
                    if (!bus.HOST_VALID || h_acc) wait_m = 0;
                    else wait_m = wait_m + 1;
`endif
                    fb_we_m = 1'b0;
                    if (s_acc) begin
                        fb_addr_m = bus.SCAN_ADDR;
                        scan_q.push_back('{col_ok(bus.SCAN_ADDR) ? mem_m[bus.SCAN_ADDR] : '0, cyc + 2});
                    end
                    if (h_acc) begin
                        fb_addr_m = bus.HOST_ADDR;
                        if (bus.HOST_WE) begin
                            fb_we_m    = col_ok(bus.HOST_ADDR);
                            fb_wdata_m = bus.HOST_WDATA;
                            if (col_ok(bus.HOST_ADDR)) mem_m[bus.HOST_ADDR] = bus.HOST_WDATA;
                        end else begin
                            host_q.push_back('{col_ok(bus.HOST_ADDR) ? mem_m[bus.HOST_ADDR] : '0, cyc + 2});
                        end
                    end
                end
                scan_taken = s_acc;
                host_taken = h_acc;
            end
            // Monitor: compares DUT outputs against the model on the falling edge.
            forever begin
                exp_t e;
                @(negedge CLOCK);
                chk("scan_ready", bus.SCAN_READY, exp_scan_ready);
                chk("host_ready", bus.HOST_READY, exp_host_ready);
                chk("stall_count", bus.STALL_COUNT, stall_m);
                chk("fb_we", bus.FB_WE, fb_we_m);
                chk("fb_addr", bus.FB_ADDR, fb_addr_m);
                if (fb_we_m) chk("fb_wdata", bus.FB_WDATA, fb_wdata_m);
                if (bus.SCAN_VALID) begin
                    if (scan_q.size() == 0) begin
                        chk("scan_unexpected_valid", bus.SCAN_VALID, 0);
                    end else begin
                        e = scan_q.pop_front();
                        chk("scan_latency", cyc, e.due);
                        chk("scan_data", bus.SCAN_DATA, e.data);
                        last_scan = e.data;
                    end
                end else begin
                    chk("scan_hold", bus.SCAN_DATA, last_scan);
                    if (scan_q.size() > 0 && scan_q[0].due <= cyc) begin
                        chk("scan_missing_valid", bus.SCAN_VALID, 1);
                        void'(scan_q.pop_front());
                    end
                end
                if (bus.HOST_RVALID) begin
                    if (host_q.size() == 0) begin
                        chk("host_unexpected_rvalid", bus.HOST_RVALID, 0);
                    end else begin
                        e = host_q.pop_front();
                        chk("host_latency", cyc, e.due);
                        chk("host_rdata", bus.HOST_RDATA, e.data);
                        last_host = e.data;
                    end
                end else begin
                    chk("host_hold", bus.HOST_RDATA, last_host);
                    if (host_q.size() > 0 && host_q[0].due <= cyc) begin
                        chk("host_missing_rvalid", bus.HOST_RVALID, 1);
                        void'(host_q.pop_front());
                    end
                end
            end
        join_none

        // Reset with both requesters active.
        bus.SCAN_REQ   = 1'b1;
        bus.HOST_VALID = 1'b1;
        bus.HOST_WE    = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        bus.SCAN_REQ   = 1'b0;
        bus.HOST_VALID = 1'b0;
        RESET_N        = 1'b1;
        idle(2);

        // Host write then scan read-back of the same pixel.
        host_cmd(1'b1, mk(3, 7), 3'b101);
        scan_read(mk(3, 7));
        idle(4);

        // Scan burst of 32 while the host waits.
        fork
            host_cmd(1'b1, mk(5, 1), 3'b011);
            scan_stream(32, 2);
        join
        idle(4);

        // Host read followed by a scan read one cycle later.
        host_cmd(1'b1, mk(0, 0), 3'b110);
        host_cmd(1'b1, mk(0, 1), 3'b001);
        idle(2);
        fork
            host_cmd(1'b0, mk(0, 0), '0);
            begin
                @(posedge CLOCK);
                #1;
                scan_read(mk(0, 1));
            end
        join
        idle(4);

        // Reset one cycle after a host read is accepted.
        host_cmd(1'b0, mk(3, 7), '0);
        RESET_N = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        idle(4);

        // Randomised mixed traffic.
        for (int c = 0; c < 2000; c++) begin
            if (!bus.SCAN_REQ || scan_taken) begin
                bus.SCAN_REQ  = ($urandom_range(0, 2) == 0);
                bus.SCAN_ADDR = A'($urandom);
            end
            if (!bus.HOST_VALID || host_taken) begin
                bus.HOST_VALID = ($urandom_range(0, 2) == 0);
                bus.HOST_WE    = 1'($urandom_range(0, 1));
                bus.HOST_ADDR  = A'($urandom);
                bus.HOST_WDATA = W'($urandom);
            end
            @(posedge CLOCK);
            #1;
        end
        idle(6);

        // Long host stall to reach counter saturation.
        bus.SCAN_REQ   = 1'b1;
        bus.SCAN_ADDR  = mk(1, 1);
        bus.HOST_VALID = 1'b1;
        bus.HOST_WE    = 1'b1;
        bus.HOST_ADDR  = mk(9, 9);
        bus.HOST_WDATA = 3'b010;
        repeat (74000) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("stall_saturated", bus.STALL_COUNT, 16'hFFFF);
        @(posedge CLOCK);
        #1;
        idle(8);

        chk("scan_queue_drained", scan_q.size(), 0);
        chk("host_queue_drained", host_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port panel framebuffer RAM between two requesters: the panel scan engine and a host pixel writer/reader.
- The scan engine has priority so the panel's shift/latch cadence is kept.
- The host uses a valid/ready handshake and is served in free cycles.
- The block sits between the scan state machine, the host-side pixel source and the framebuffer RAM. The RAM has 1-cycle registered read latency.

Parameters:
COLS, 32, panel columns; col field width COL_BITS = bits_for(COLS-1)
ROWS, 16, panel rows; row field width ROW_BITS = bits_for(ROWS-1)
COLOR_DEPTH, 1, bits per colour channel; pixel width RGB_WIDTH = 3*COLOR_DEPTH
MAX_WAIT, 8, host starvation limit in cycles; used only with the optional feature

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESET_N  in  1  synchronous active-low reset
SCAN_REQ  in  1  scan read request; held high until accepted
SCAN_ADDR  in  ROW_BITS+COL_BITS  {row,col} pixel address
SCAN_READY  out  1  scan request accepted this cycle
SCAN_DATA  out  RGB_WIDTH  read pixel
SCAN_VALID  out  1  SCAN_DATA valid, 1-cycle pulse
HOST_VALID  in  1  host command valid
HOST_READY  out  1  host command accepted this cycle
HOST_WE  in  1  1=write, 0=read
HOST_ADDR  in  ROW_BITS+COL_BITS  {row,col} pixel address
HOST_WDATA  in  RGB_WIDTH  write pixel
HOST_RDATA  out  RGB_WIDTH  read pixel
HOST_RVALID  out  1  HOST_RDATA valid, 1-cycle pulse
FB_ADDR  out  ROW_BITS+COL_BITS  RAM address (registered)
FB_WE  out  1  RAM write enable (registered)
FB_WDATA  out  RGB_WIDTH  RAM write data (registered)
FB_RDATA  in  RGB_WIDTH  RAM read data, valid 1 cycle after FB_ADDR
STALL_COUNT  out  16  saturating count of host wait cycles

Behaviour:
- The clock port is named CLOCK; the reset port is RESET_N. Reset is synchronous and active-low. One clock domain.
- Reset values:
  - FB_WE=0, FB_ADDR=0, FB_WDATA=0.
  - SCAN_VALID=0, HOST_RVALID=0, SCAN_DATA=0, HOST_RDATA=0.
  - STALL_COUNT=0; wait counter=0; read-tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and no VALID pulse is emitted for them.
- Grant is combinational on the current inputs:
  - Without a forced host slot: SCAN_READY = SCAN_REQ; HOST_READY = HOST_VALID & ~SCAN_REQ.
  - At most one grant per cycle.
- Cycle t (grant): the accepted command is registered into FB_ADDR, FB_WE and FB_WDATA.
  - A scan grant always produces FB_WE=0.
  - A host write produces FB_WE=1.
  - No grant: FB_WE=0, FB_ADDR and FB_WDATA hold their previous values.
- Cycle t+1: the RAM presents FB_RDATA.
- Cycle t+2: the data is registered to SCAN_DATA or HOST_RDATA, and the matching VALID pulses.
  - Read latency is exactly 2 cycles from the accept cycle.
  - A 2-deep tag shift register {valid, owner} records the requester of each read.
- Host writes produce no HOST_RVALID.
- Back-to-back grants every cycle are legal with full throughput; scan and host may alternate cycle by cycle.
- Column field >= COLS (non-power-of-2 COLS only):
  - The command is still accepted.
  - A write is dropped (FB_WE=0).
  - A read returns 0 with its VALID pulse.
- STALL_COUNT increments each cycle HOST_VALID=1 & HOST_READY=0 and saturates at 16'hFFFF.
- SCAN_DATA and HOST_RDATA hold their last value while VALID=0.

Optional Feature:
Macro FB_ARB_STARVE_GUARD_EN.
- Defined:
  - A wait counter, width bits_for(MAX_WAIT), counts consecutive cycles with HOST_VALID & ~HOST_READY.
  - When the counter equals MAX_WAIT, the next cycle forces a host slot: HOST_READY=1 and SCAN_READY=0 even if SCAN_REQ=1.
  - The counter clears on any host accept, and when HOST_VALID=0.
  - The scan engine must tolerate SCAN_READY=0.
- Undefined:
  - Strict scan priority; no wait counter is present.
  - MAX_WAIT is ignored.
  - SCAN_READY == SCAN_REQ always.

Test Plan:
- Reset with RESET_N=0 for 2 cycles while SCAN_REQ=1 and HOST_VALID=1 -> FB_WE=0, SCAN_VALID=0, HOST_RVALID=0, STALL_COUNT=0 throughout reset.
- Host writes 3'b101 to {row 3, col 7}, then scan reads the same address -> FB_WE=1 for one cycle, then SCAN_VALID exactly 2 cycles after the scan accept with SCAN_DATA=3'b101.
- Scan streams 32 consecutive reads while HOST_VALID=1:
  - Macro undefined: HOST_READY=0 for 32 cycles, STALL_COUNT=32, and the host is accepted on cycle 33.
  - Macro defined, MAX_WAIT=8: the host is accepted after 8 wait cycles, with SCAN_READY=0 in that cycle.
- Interleave host read {row 0, col 0} with a scan read on the next cycle -> HOST_RVALID and SCAN_VALID on consecutive cycles, each carrying its own data with no tag swap.
- Assert RESET_N=0 one cycle after a host read accept -> no HOST_RVALID emitted afterwards.
- Force 70000 host stall cycles -> STALL_COUNT saturates at 16'hFFFF.
